// File: rtl/calc_pkg.sv
// Shared types and sign-magnitude helpers for the calculator arithmetic path.
// Conversions use a fixed MAX_W-wide container; MAG_W must stay below MAX_W.
package calc_pkg;

  localparam int MAX_W = 32;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_MUL = 2'b01,
    OP_SUB = 2'b10,
    OP_DIV = 2'b11
  } opcode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DIV  = 1'b1
  } state_t;

  localparam logic [MAX_W+1:0] ONE_TC = {{(MAX_W+1){1'b0}}, 1'b1};

  // Sign-magnitude to (MAX_W+2)-bit two's complement.
  function automatic logic [MAX_W+1:0] sm_to_tc(input logic sign, input logic [MAX_W-1:0] mag);
    logic [MAX_W+1:0] ext;
    ext = {2'b00, mag};
    return sign ? (~ext + ONE_TC) : ext;
  endfunction

  // Magnitude of a (MAX_W+2)-bit two's complement value; the sign is its MSB.
  function automatic logic [MAX_W+1:0] tc_to_mag(input logic [MAX_W+1:0] tc);
    return tc[MAX_W+1] ? (~tc + ONE_TC) : tc;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle MSB first.
// The first step runs on the start edge, so done pulses exactly W cycles after start.
module seq_divider #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem_reg, quo_reg, dvs_reg;
  logic [CW-1:0] count_reg;
  logic          busy_reg, done_reg;

  logic          start_ok;
  logic [W-1:0]  rem_cur, quo_cur, dvs_cur;
  logic [W:0]    shifted;
  logic [W+1:0]  trial;
  logic          fits;
  logic [W-1:0]  rem_next, quo_next;

  assign start_ok = start & ~busy_reg;

  always_comb begin
    rem_cur  = start_ok ? '0 : rem_reg;
    quo_cur  = start_ok ? dividend : quo_reg;
    dvs_cur  = start_ok ? divisor : dvs_reg;
    shifted  = {rem_cur, quo_cur[W-1]};
    trial    = {1'b0, shifted} - {2'b00, dvs_cur};
    fits     = ~trial[W+1];
    rem_next = fits ? trial[W-1:0] : shifted[W-1:0];
    quo_next = {quo_cur[W-2:0], fits};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rem_reg   <= '0;
      quo_reg   <= '0;
      dvs_reg   <= '0;
      count_reg <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (abort) begin
        busy_reg <= 1'b0;
      end else if (start_ok) begin
        rem_reg   <= rem_next;
        quo_reg   <= quo_next;
        dvs_reg   <= divisor;
        count_reg <= CW'(W - 1);
        busy_reg  <= 1'b1;
      end else if (busy_reg) begin
        rem_reg <= rem_next;
        quo_reg <= quo_next;
        if (count_reg == CW'(1)) begin
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
        end else begin
          count_reg <= count_reg - CW'(1);
        end
      end
    end
  end

  assign quotient = quo_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

endmodule

// File: rtl/calc_arith_seq.sv
// Sign-magnitude add/sub/mul in one cycle and divide via seq_divider.
// Overflow and divide-by-zero become visible only while omode (set by eq) holds.
module calc_arith_seq
  import calc_pkg::*;
#(
  parameter int MAG_W = 16
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [MAG_W:0] v1,
  input  logic [MAG_W:0] v2,
  input  logic [1:0]     opcode,
  input  logic           newop,
  input  logic           newhex,
  input  logic           eq,
  output logic [MAG_W:0] answer,
  output logic           ovw_out,
  output logic           busy,
  output logic           done
);

  localparam int PAD = MAX_W - MAG_W;

  opcode_t        op_reg;
  state_t         state_reg;
  logic [MAG_W:0] answer_reg;
  logic           ovw_reg, omode_reg, done_reg;
  logic           div_sign_reg, div_zero_reg;

  logic             sign1, sign2;
  logic [MAG_W-1:0] mag1, mag2;
  logic             key;
  logic             launch;
  logic [MAX_W+1:0] tc1, tc2, tc_res, res_mag;
  logic [2*MAG_W-1:0] prod;
  logic             sc_sign, sc_ovf;
  logic [MAG_W-1:0] sc_mag;
  logic [MAG_W:0]   sc_answer;

  logic             div_start, div_abort, div_busy, div_done;
  logic [MAG_W-1:0] div_quo;

  assign sign1  = v1[MAG_W];
  assign sign2  = v2[MAG_W];
  assign mag1   = v1[MAG_W-1:0];
  assign mag2   = v2[MAG_W-1:0];
  assign key    = newop | newhex;
  assign launch = eq & ~key & (state_reg == ST_IDLE);

  always_comb begin
    tc1     = sm_to_tc(sign1, {{PAD{1'b0}}, mag1});
    tc2     = sm_to_tc(sign2, {{PAD{1'b0}}, mag2});
    tc_res  = (op_reg == OP_SUB) ? (tc2 - tc1) : (tc2 + tc1);
    res_mag = tc_to_mag(tc_res);
    prod    = {{MAG_W{1'b0}}, mag1} * {{MAG_W{1'b0}}, mag2};
    sc_sign = tc_res[MAX_W+1];
    sc_mag  = res_mag[MAG_W-1:0];
    sc_ovf  = |res_mag[MAX_W+1:MAG_W];
    if (op_reg == OP_MUL) begin
      sc_sign = sign1 ^ sign2;
      sc_mag  = prod[MAG_W-1:0];
      sc_ovf  = |prod[2*MAG_W-1:MAG_W];
    end
    // Zero magnitude is always reported with a positive sign.
    sc_answer = sc_ovf ? '0 : {sc_sign & (|sc_mag), sc_mag};
  end

  assign div_start = launch & (op_reg == OP_DIV);
  assign div_abort = key & (state_reg == ST_DIV);

  seq_divider #(.W(MAG_W)) u_div (
    .clock    (clock),
    .reset    (reset),
    .start    (div_start),
    .abort    (div_abort),
    .dividend (mag2),
    .divisor  (mag1),
    .quotient (div_quo),
    .busy     (div_busy),
    .done     (div_done)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      op_reg       <= OP_ADD;
      state_reg    <= ST_IDLE;
      answer_reg   <= '0;
      ovw_reg      <= 1'b0;
      omode_reg    <= 1'b0;
      done_reg     <= 1'b0;
      div_sign_reg <= 1'b0;
      div_zero_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (newop) op_reg <= opcode_t'(opcode);
      if (key) begin
        ovw_reg   <= 1'b0;
        omode_reg <= 1'b0;
        state_reg <= ST_IDLE;
      end else if (launch) begin
        omode_reg <= 1'b1;
        if (op_reg == OP_DIV) begin
          state_reg    <= ST_DIV;
          div_sign_reg <= sign1 ^ sign2;
          div_zero_reg <= (mag1 == '0);
        end else begin
          answer_reg <= sc_answer;
          ovw_reg    <= sc_ovf;
          done_reg   <= 1'b1;
        end
      end else if (state_reg == ST_DIV && div_done) begin
        state_reg <= ST_IDLE;
        done_reg  <= 1'b1;
        ovw_reg   <= div_zero_reg;
        answer_reg <= div_zero_reg ? '0 : {div_sign_reg & (|div_quo), div_quo};
      end
    end
  end

  assign answer  = answer_reg;
  assign ovw_out = ovw_reg & omode_reg;
  assign busy    = (state_reg == ST_DIV);
  assign done    = done_reg;

  logic unused_ok;
  assign unused_ok = div_busy;

endmodule
